v810_bus_ctrl: RTL and testbench

Parametrised external-bus responder for the V810 memory access unit. It decodes each bus cycle against NREG programmable address regions and inserts the per-region wait states. It answers bus sizing for 16-bit regions and steers data lanes. It drives one chip enable per region. It generalises the fixed single-device wait-state/width resizer into a multi-region, runtime-configurable controller with miss detection and halt/fault-acknowledge handling.

---
 rtl/v810_bus_pkg.sv | 29 ++
 rtl/v810_bus_if.sv | 42 ++++
 rtl/v810_bus_decode.sv | 28 ++
 rtl/v810_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_v810_bus_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the V810 external-bus responder.
// The region index is sized for the largest supported NREG (8).
package v810_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    WAIT = 2'd2,
    LAST = 2'd3
  } state_t;

  localparam int NREG_MAX  = 8;
  localparam int REG_IDX_W = $clog2(NREG_MAX);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     miss;
    reg_idx_t idx;
  } region_t;

  localparam region_t REGION_MISS = '{miss: 1'b1, idx: '0};

  // ST[ST_ACK_BIT] marks a halt/fault acknowledge on a non-memory cycle
  localparam int         ST_ACK_BIT = 0;
  localparam logic [1:0] ST_MEM     = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;

endpackage

// File: rtl/v810_bus_if.sv
// V810 bus, device-side data/enables and region configuration in one bundle.
// slave = the bus controller, master = CPU, memory devices and config source.
interface v810_bus_if #(
  parameter int NREG = 4,
  parameter int WSW  = 4
);

  logic [31:0]               A;
  logic [3:0]                BEn;
  logic [1:0]                ST;
  logic                      DAn;
  logic                      MRQn;
  logic                      RW;
  logic                      BCYSTn;
  logic                      READYn;
  logic                      SZRQn;
  logic [31:0]               D_O;
  logic [31:0]               D_I;      // write data from the execution unit
  logic [31:0]               MEM_DO;
  logic [31:0]               MEM_DI;
  logic [NREG-1:0]           MEM_nCE;
  logic [NREG-1:0][31:0]     CFG_BASE;
  logic [NREG-1:0][31:0]     CFG_MASK;
  logic [NREG-1:0][WSW-1:0]  CFG_WS;
  logic [NREG-1:0]           CFG_DW16;
  logic                      HALT_ACK;
  logic                      MISS;
  logic                      PROTO_ERR;

  modport slave (
    input  A, BEn, ST, DAn, MRQn, RW, BCYSTn, D_I, MEM_DO,
    input  CFG_BASE, CFG_MASK, CFG_WS, CFG_DW16,
    output READYn, SZRQn, D_O, MEM_DI, MEM_nCE, HALT_ACK, MISS, PROTO_ERR
  );

  modport master (
    output A, BEn, ST, DAn, MRQn, RW, BCYSTn, D_I, MEM_DO,
    output CFG_BASE, CFG_MASK, CFG_WS, CFG_DW16,
    input  READYn, SZRQn, D_O, MEM_DI, MEM_nCE, HALT_ACK, MISS, PROTO_ERR
  );

endinterface

// File: rtl/v810_bus_decode.sv
// Combinational priority region matcher: hit when (a & mask) == base,
// lowest matching index wins.
module v810_bus_decode
  import v810_bus_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic [31:0]           a,
  input  logic [NREG-1:0][31:0] cfg_base,
  input  logic [NREG-1:0][31:0] cfg_mask,
  output logic                  hit,
  output reg_idx_t              idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((a & cfg_mask[i]) == cfg_base[i]) begin
        hit = 1'b1;
        idx = reg_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/v810_bus_ctrl.sv
// V810 external-bus responder: region decode, per-region wait states,
// 16-bit bus sizing and lane steering, miss and halt-acknowledge handling.
module v810_bus_ctrl
  import v810_bus_pkg::*;
#(
  parameter int NREG    = 4,
  parameter int WSW     = 4,
  parameter int MISS_WS = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CE,
  v810_bus_if.slave  bus
);

  state_t         state_q, state_d;
  logic [WSW-1:0] wait_q, wait_d;
  region_t        region_q, region_d;
  logic           mem_q, mem_d;
  logic           rw_q, rw_d;
  logic           a1_q, a1_d;
  logic [3:0]     ben_q, ben_d;
  logic           dw16_q, dw16_d;
  logic           st_ack_q, st_ack_d;
  logic           proto_err_q, proto_err_d;

  logic           dec_hit;
  reg_idx_t       dec_idx;
  logic           accept;

  v810_bus_decode #(.NREG(NREG)) u_decode (
    .a        (bus.A),
    .cfg_base (bus.CFG_BASE),
    .cfg_mask (bus.CFG_MASK),
    .hit      (dec_hit),
    .idx      (dec_idx)
  );

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    region_d    = region_q;
    mem_d       = mem_q;
    rw_d        = rw_q;
    a1_d        = a1_q;
    ben_d       = ben_q;
    dw16_d      = dw16_q;
    st_ack_d    = st_ack_q;
    proto_err_d = proto_err_q;
    accept      = 1'b0;

    unique case (state_q)
      IDLE: accept = !bus.BCYSTn;
      T1: begin
        proto_err_d = proto_err_q | !bus.BCYSTn;
        state_d     = (wait_q != '0) ? WAIT : LAST;
      end
      WAIT: begin
        proto_err_d = proto_err_q | !bus.BCYSTn;
        wait_d      = wait_q - WSW'(1);
        if (wait_q == WSW'(1)) state_d = LAST;
      end
      LAST: begin
        state_d = IDLE;
        accept  = !bus.BCYSTn;
      end
      default: state_d = IDLE;
    endcase

    // Config is sampled here only; later changes cannot disturb this cycle.
    if (accept) begin
      state_d  = T1;
      mem_d    = !bus.MRQn;
      rw_d     = bus.RW;
      a1_d     = bus.A[1];
      ben_d    = bus.BEn;
      st_ack_d = bus.ST[ST_ACK_BIT];
      region_d = REGION_MISS;
      dw16_d   = 1'b0;
      wait_d   = '0;
      if (!bus.MRQn) begin
        if (dec_hit) begin
          region_d = '{miss: 1'b0, idx: dec_idx};
          for (int i = 0; i < NREG; i++) begin
            if (dec_idx == reg_idx_t'(i)) begin
              dw16_d = bus.CFG_DW16[i];
              wait_d = bus.CFG_WS[i];
            end
          end
        end else begin
          wait_d = WSW'(MISS_WS);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is
  // synchronous and wins over CE so an aborted cycle never reaches LAST.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      region_q    <= REGION_MISS;
      mem_q       <= 1'b0;
      rw_q        <= 1'b0;
      a1_q        <= 1'b0;
      ben_q       <= 4'hF;
      dw16_q      <= 1'b0;
      st_ack_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else if (CE) begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      region_q    <= region_d;
      mem_q       <= mem_d;
      rw_q        <= rw_d;
      a1_q        <= a1_d;
      ben_q       <= ben_d;
      dw16_q      <= dw16_d;
      st_ack_q    <= st_ack_d;
      proto_err_q <= proto_err_d;
    end
  end

  logic            busy, last, mem_hit, both_halves;
  logic [NREG-1:0] nce;
  logic [31:0]     d_o;

  assign busy        = (state_q != IDLE);
  assign last        = (state_q == LAST);
  assign mem_hit     = mem_q && !region_q.miss;
  assign both_halves = (ben_q[1:0] != 2'b11) && (ben_q[3:2] != 2'b11);

  // Handshake outputs depend on registered state only.
  always_comb begin
    nce = '1;
    if (busy && mem_hit) begin
      for (int i = 0; i < NREG; i++) begin
        if (region_q.idx == reg_idx_t'(i)) nce[i] = 1'b0;
      end
    end
  end

  always_comb begin
    d_o = '0;
    if (last && rw_q && mem_hit) begin
      if (!dw16_q)   d_o = bus.MEM_DO;
      else if (a1_q) d_o = {bus.MEM_DO[15:0], 16'h0000};
      else           d_o = {16'h0000, bus.MEM_DO[15:0]};
    end
  end

  assign bus.READYn    = !last;
  assign bus.SZRQn     = !(last && mem_hit && dw16_q && both_halves);
  assign bus.MEM_nCE   = nce;
  assign bus.D_O       = d_o;
  assign bus.MEM_DI    = dw16_q ? {16'h0000, (a1_q ? bus.D_I[31:16] : bus.D_I[15:0])}
                                : bus.D_I;
  assign bus.MISS      = last && mem_q && region_q.miss;
  assign bus.HALT_ACK  = last && !mem_q && st_ack_q;
  assign bus.PROTO_ERR = proto_err_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.DAn, bus.ST[1]};

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Bench for v810_bus_ctrl: directed vector table, randomized traffic against
// a transaction-level model, and hand-written protocol/reset/CE sequences.
module tb_v810_bus_ctrl;
  import v810_bus_pkg::*;

  localparam int NREG    = 4;
  localparam int WSW     = 4;
  localparam int MISS_WS = 2;

  logic clk = 1'b0;
  logic res;
  logic ce;

  v810_bus_if #(.NREG(NREG), .WSW(WSW)) bus ();

  v810_bus_ctrl #(.NREG(NREG), .WSW(WSW), .MISS_WS(MISS_WS)) dut (
    .CLK (clk),
    .RES (res),
    .CE  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  ben;
    logic        rw;
    logic        mrqn;
    logic [1:0]  st;
    logic [31:0] mem_do;
    logic [31:0] d_i;
  } txn_t;

  typedef struct {
    int              ws;
    logic [NREG-1:0] nce;
    logic            szrqn;
    logic            chk_do;
    logic [31:0]     d_o;
    logic            miss;
    logic            halt;
    logic [31:0]     di;
    logic [31:0]     di_mask;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_table_cfg;
    bus.CFG_BASE[0] = 32'h0000_0000; bus.CFG_MASK[0] = 32'hF000_0000;
    bus.CFG_WS[0]   = 4'd0;          bus.CFG_DW16[0] = 1'b0;
    bus.CFG_BASE[1] = 32'h8000_0000; bus.CFG_MASK[1] = 32'hF000_0000;
    bus.CFG_WS[1]   = 4'd3;          bus.CFG_DW16[1] = 1'b1;
    bus.CFG_BASE[2] = 32'h0100_0000; bus.CFG_MASK[2] = 32'hFF00_0000;
    bus.CFG_WS[2]   = 4'd1;          bus.CFG_DW16[2] = 1'b0;
    bus.CFG_BASE[3] = 32'h4000_0000; bus.CFG_MASK[3] = 32'hF000_0000;
    bus.CFG_WS[3]   = 4'd2;          bus.CFG_DW16[3] = 1'b1;
  endtask

  // Expected behaviour of one bus cycle derived from the current config.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int   r = -1;
    for (int i = 0; i < NREG; i++)
      if (r < 0 && (t.a & bus.CFG_MASK[i]) == bus.CFG_BASE[i]) r = i;
    e.ws = 0; e.nce = '1; e.szrqn = 1'b1; e.chk_do = t.rw; e.d_o = '0;
    e.miss = 1'b0; e.halt = 1'b0; e.di = '0; e.di_mask = '0;
    if (t.mrqn) begin
      e.halt = t.st[0];
    end else if (r < 0) begin
      e.ws   = MISS_WS;
      e.miss = 1'b1;
    end else begin
      e.ws     = int'(bus.CFG_WS[r]);
      e.nce[r] = 1'b0;
      if (bus.CFG_DW16[r]) begin
        e.szrqn   = !(t.ben[1:0] != 2'b11 && t.ben[3:2] != 2'b11);
        e.d_o     = t.a[1] ? {t.mem_do[15:0], 16'h0} : {16'h0, t.mem_do[15:0]};
        e.di      = {16'h0, (t.a[1] ? t.d_i[31:16] : t.d_i[15:0])};
        e.di_mask = 32'h0000_FFFF;
      end else begin
        e.d_o     = t.mem_do;
        e.di      = t.d_i;
        e.di_mask = 32'hFFFF_FFFF;
      end
    end
    return e;
  endfunction

  // Starts a cycle on the next edge, then counts enabled edges until LAST.
  task automatic run_txn(input txn_t t, input exp_t e, input bit stalls, input string tag);
    int need  = e.ws + 2;
    int done  = 1;
    int guard = 0;
    int k;
    bus.A = t.a; bus.BEn = t.ben; bus.RW = t.rw; bus.MRQn = t.mrqn; bus.ST = t.st;
    bus.MEM_DO = t.mem_do; bus.D_I = t.d_i; bus.BCYSTn = 1'b0; ce = 1'b1;
    tick;
    bus.BCYSTn = 1'b1;
    while (done < need) begin
      check($sformatf("%s.readyn_busy", tag), bus.READYn, 1'b1);
      check($sformatf("%s.nce_busy", tag), bus.MEM_nCE, e.nce);
      check($sformatf("%s.pulses_busy", tag), {bus.MISS, bus.HALT_ACK}, 2'b00);
      ce = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stalls && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NREG - 1);
        bus.CFG_WS[k] = WSW'($urandom_range(0, 15));
      end
      tick;
      if (ce) done++;
      guard++;
      if (guard > 500) begin
        check($sformatf("%s.timeout", tag), 1'b1, 1'b0);
        break;
      end
    end
    ce = 1'b1;
    check($sformatf("%s.readyn", tag), bus.READYn, 1'b0);
    check($sformatf("%s.szrqn", tag), bus.SZRQn, e.szrqn);
    check($sformatf("%s.nce", tag), bus.MEM_nCE, e.nce);
    check($sformatf("%s.miss", tag), bus.MISS, e.miss);
    check($sformatf("%s.halt_ack", tag), bus.HALT_ACK, e.halt);
    check($sformatf("%s.proto_err", tag), bus.PROTO_ERR, 1'b0);
    if (e.chk_do) check($sformatf("%s.d_o", tag), bus.D_O, e.d_o);
    if (!t.rw) check($sformatf("%s.mem_di", tag), bus.MEM_DI & e.di_mask, e.di & e.di_mask);
  endtask

  vec_t vecs[12];
  txn_t t;
  exp_t e;
  bit   seen;

  initial begin
    res = 1'b1; ce = 1'b1;
    bus.A = '0; bus.BEn = 4'hF; bus.ST = 2'b00; bus.DAn = 1'b1; bus.MRQn = 1'b0;
    bus.RW = 1'b1; bus.BCYSTn = 1'b1; bus.D_I = '0; bus.MEM_DO = '0;
    set_table_cfg();
    tick;
    tick;
    check("reset.readyn", bus.READYn, 1'b1);
    check("reset.szrqn", bus.SZRQn, 1'b1);
    check("reset.nce", bus.MEM_nCE, 4'hF);
    check("reset.d_o", bus.D_O, 32'h0);
    check("reset.halt_ack", bus.HALT_ACK, 1'b0);
    check("reset.miss", bus.MISS, 1'b0);
    check("reset.proto_err", bus.PROTO_ERR, 1'b0);
    res = 1'b0;
    tick;

    //              a              ben    rw    mrqn  st     mem_do         d_i
    //              ws nce      szrqn chk_do d_o        miss  halt  di             di_mask
    vecs[0]  = '{'{32'h0000_0010, 4'h0, 1'b1, 1'b0, 2'b00, 32'hCAFE_F00D, 32'h0},
                 '{0, 4'b1110, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[1]  = '{'{32'h8000_0000, 4'h0, 1'b1, 1'b0, 2'b00, 32'h1234_5678, 32'h0},
                 '{3, 4'b1101, 1'b0, 1'b1, 32'h0000_5678, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[2]  = '{'{32'h8000_0002, 4'h3, 1'b1, 1'b0, 2'b00, 32'hAAAA_BEEF, 32'h0},
                 '{3, 4'b1101, 1'b1, 1'b1, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[3]  = '{'{32'h0100_0000, 4'h0, 1'b1, 1'b0, 2'b00, 32'h0BAD_CAFE, 32'h0},
                 '{0, 4'b1110, 1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[4]  = '{'{32'hC000_0000, 4'h0, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0},
                 '{2, 4'b1111, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0}};
    vecs[5]  = '{'{32'h8000_0000, 4'h0, 1'b1, 1'b1, ST_HALT, 32'h1111_2222, 32'h0},
                 '{0, 4'b1111, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0}};
    vecs[6]  = '{'{32'h4000_0002, 4'h3, 1'b0, 1'b0, 2'b00, 32'h0, 32'h5555_AAAA},
                 '{2, 4'b0111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_5555, 32'h0000_FFFF}};
    vecs[7]  = '{'{32'h4000_0000, 4'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h1357_2468},
                 '{2, 4'b0111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_2468, 32'h0000_FFFF}};
    vecs[8]  = '{'{32'h0200_0000, 4'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'hDEAD_BEEF},
                 '{0, 4'b1110, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF}};
    vecs[9]  = '{'{32'h0000_0040, 4'h0, 1'b1, 1'b1, 2'b10, 32'h0000_0005, 32'h0},
                 '{0, 4'b1111, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[10] = '{'{32'h8000_0000, 4'hC, 1'b1, 1'b0, 2'b00, 32'h9876_5432, 32'h0},
                 '{3, 4'b1101, 1'b1, 1'b1, 32'h0000_5432, 1'b0, 1'b0, 32'h0, 32'h0}};
    vecs[11] = '{'{32'h4000_0002, 4'h0, 1'b1, 1'b0, 2'b00, 32'h0000_7777, 32'h0},
                 '{2, 4'b0111, 1'b0, 1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0, 32'h0}};

    // Rows follow each other with no idle gap, exercising back-to-back cycles.
    for (int i = 0; i < 12; i++) run_txn(vecs[i].t, vecs[i].e, 1'b0, $sformatf("vec%0d", i));

    // Randomized traffic with CE stalls and mid-cycle wait-state rewrites.
    for (int i = 0; i < NREG; i++) begin
      bus.CFG_MASK[i] = $urandom_range(0, 1) ? 32'hF000_0000 : 32'hFF00_0000;
      bus.CFG_BASE[i] = $urandom & bus.CFG_MASK[i];
      bus.CFG_WS[i]   = WSW'($urandom_range(0, 15));
      bus.CFG_DW16[i] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 300; n++) begin
      int r;
      if ($urandom_range(0, 2) == 0) begin
        bus.BCYSTn = 1'b1;
        tick;
        check("rand.readyn_idle", bus.READYn, 1'b1);
        repeat ($urandom_range(0, 2)) tick;
      end
      r = $urandom_range(0, NREG);
      t.a      = (r < NREG) ? (bus.CFG_BASE[r] | ($urandom & ~bus.CFG_MASK[r])) : $urandom;
      t.ben    = 4'($urandom);
      t.rw     = 1'($urandom);
      t.mrqn   = ($urandom_range(0, 5) == 0);
      t.st     = 2'($urandom);
      t.mem_do = $urandom;
      t.d_i    = $urandom;
      e = model(t);
      run_txn(t, e, 1'b1, $sformatf("rand%0d", n));
    end

    // CE low while in LAST holds READYn low.
    set_table_cfg();
    bus.BCYSTn = 1'b1;
    tick;
    bus.A = 32'h0000_0010; bus.BEn = 4'h0; bus.RW = 1'b1; bus.MRQn = 1'b0; bus.BCYSTn = 1'b0;
    tick;
    bus.BCYSTn = 1'b1;
    tick;
    check("ce.readyn_last", bus.READYn, 1'b0);
    ce = 1'b0;
    tick;
    tick;
    check("ce.readyn_hold", bus.READYn, 1'b0);
    ce = 1'b1;
    tick;
    check("ce.readyn_release", bus.READYn, 1'b1);

    // BCYSTn during WAIT flags PROTO_ERR and the cycle still completes.
    bus.A = 32'h8000_0000; bus.BCYSTn = 1'b0;
    tick;
    bus.BCYSTn = 1'b1;
    tick;
    bus.BCYSTn = 1'b0;
    tick;
    bus.BCYSTn = 1'b1;
    check("proto.set", bus.PROTO_ERR, 1'b1);
    check("proto.readyn_busy", bus.READYn, 1'b1);
    tick;
    tick;
    check("proto.readyn_complete", bus.READYn, 1'b0);
    check("proto.nce", bus.MEM_nCE, 4'b1101);
    tick;
    check("proto.sticky", bus.PROTO_ERR, 1'b1);

    // RES during WAIT aborts the cycle with no READYn.
    bus.BCYSTn = 1'b0;
    tick;
    bus.BCYSTn = 1'b1;
    tick;
    res = 1'b1;
    tick;
    check("abort.readyn", bus.READYn, 1'b1);
    check("abort.nce", bus.MEM_nCE, 4'hF);
    check("abort.proto_err", bus.PROTO_ERR, 1'b0);
    check("abort.d_o", bus.D_O, 32'h0);
    res = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (bus.READYn !== 1'b1) seen = 1'b1;
    end
    check("abort.no_readyn", seen, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
